fp_issue_queue: RTL and testbench
=================================

// Module: fp_issue_queue
// PURPOSE
//  In-order issue stage directly downstream of fp_decoder. Buffers decoded FP ops in a small FIFO.
//  Tracks pending FP-register writes in a busy-bit scoreboard.
//  Releases the head op to the FP execute unit only when it has no RAW/WAW hazard on FP registers.
//  Writeback from execute clears busy bits.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of two, >=2
//  NUM_FPR   32  FP architectural registers tracked by the scoreboard
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    decoded op present from fp_decoder
//  in_ready   out  1    queue can accept (not full)
//  in_op      in   fp_dec_op_t  {fp_op[6:0],rs1,rs2,rs3,rd[4:0],offset s12,fp_read,fp_write,rm[2:0]}
//  iss_valid  out  1    head op issuable this cycle
//  iss_ready  in   1    execute unit accepts
//  iss_op     out  fp_dec_op_t  head op; stable while iss_valid && !iss_ready
//  wb_valid   in   1    execute writes FP register wb_rd this cycle
//  wb_rd      in   5    destination being retired
//  count      out  $clog2(DEPTH)+1  current occupancy
//  flush      in   1    (only with FP_ISSUE_FLUSH_EN) discard all queued ops
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, wr/rd ptrs=0, count=0, all busy bits=0.
//   Outputs in_ready=1, iss_valid=0, iss_op=0.
//  Enqueue when in_valid && in_ready. in_ready = (count!=DEPTH); combinational from registered count.
//  Dequeue when iss_valid && iss_ready. Enqueue and dequeue in the same cycle are allowed when full:
//   no. in_ready ignores same-cycle dequeue; when full, in_ready=0.
//  Pointers: $clog2(DEPTH) bits, natural wrap; count +1/-1/0 on enq/deq/both.
//  Source checks on the head op:
//   rs1 checked when fp_op==7'b1010011 (OP-FP) or FMA.
//   rs2 checked when fp_read.
//   rs3 checked when FMA (fp_op[6:4]==3'b100 && fp_op[1:0]==2'b11).
//   Over-stalling on integer-source OP-FP (e.g. FCVT.S.W) is accepted.
//  hazard = any checked rsN with busy_eff[rsN], or (fp_write && busy_eff[rd]).
//   busy_eff = busy & ~(wb_valid ? onehot(wb_rd) : 0); same-cycle writeback releases the stall.
//  iss_valid = (count!=0) && !hazard. Issue latency: an op enqueued in cycle N may issue in N+1 at
//   the earliest. No bypass from the input to the output.
//  Scoreboard update per cycle:
//   - issue with fp_write sets busy[rd];
//   - wb_valid clears busy[wb_rd];
//   - same index both cases: set wins.
//  wb_valid for a non-busy register: no effect; must not corrupt other bits.
//  Head op with fp_write=0 and fp_read=0 (no FP regs touched): never stalls.
// CONFIGURATION
//  FP_ISSUE_FLUSH_EN defined: flush port exists.
//   - flush=1 empties the FIFO next edge (ptrs/count=0); a same-cycle enqueue is dropped.
//   - iss_valid is forced 0 in the flush cycle.
//   - Scoreboard is NOT cleared: in-flight ops still write back.
//  Undefined: no flush port; queue drains only via issue.
// STRUCTURE
//  fp_types_pkg: fp_dec_op_t packed struct, OPC_OP_FP=7'b1010011, is_fma() function, FPR_W=5.
//  Sub-module fp_scoreboard: busy vector, set/clear ports, combinational busy_eff query for 4
//   indices. Parent holds the FIFO and hazard/issue logic.
// TESTING
//  Reset mid-stream: 3 ops queued, busy[5]=1, drop rst -> count=0, iss_valid=0, in_ready=1,
//   busy all 0, with no clock edge needed.
//  RAW: FADD.S rd=f5, then FMUL.S rs1=f5. First issues. Second holds iss_valid=0 until wb_valid,
//   wb_rd=5; issues that same cycle.
//  WAW: two FLW rd=f3 back to back. Second stalls until wb_rd=3. Simultaneous issue+wb on f3
//   leaves busy[3]=1.
//  FMA rs3: FMADD.S rs3=f7 with busy[7]=1 stalls. Same op with fp_op=OP-FP ignores rs3 and issues.
//  Full/backpressure: iss_ready=0, enqueue DEPTH=4 independent ops -> count=4, in_ready=0.
//   5th held. Release iss_ready -> FIFO order preserved, count decrements each cycle.
//  Flush (FP_ISSUE_FLUSH_EN): 2 queued, busy[9]=1, flush=1 with in_valid=1 -> count=0,
//   busy[9] still 1, new op not stored.

Source files
------------

// File: rtl/fp_types_pkg.sv
// Shared types for the FP issue path: the decoded-op record that fp_decoder
// hands downstream, the OP-FP major opcode and the FMA opcode-group test.
package fp_types_pkg;

  localparam int FPR_W = 5;
  localparam logic [6:0] OPC_OP_FP = 7'b1010011;

  typedef struct packed {
    logic [6:0]        fp_op;
    logic [FPR_W-1:0]  rs1;
    logic [FPR_W-1:0]  rs2;
    logic [FPR_W-1:0]  rs3;
    logic [FPR_W-1:0]  rd;
    logic signed [11:0] offset;
    logic              fp_read;
    logic              fp_write;
    logic [2:0]        rm;
  } fp_dec_op_t;

  // FMADD/FMSUB/FNMSUB/FNMADD all match 100xx11; bits [3:2] select the variant.
  function automatic logic is_fma(input logic [6:0] fp_op);
    return (fp_op & 7'b111_0011) == 7'b100_0011;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Busy-bit scoreboard for FP architectural registers. One set port (issue of
// an FP-writing op) and one clear port (writeback). Queries see the
// writeback-adjusted view so a same-cycle writeback releases a stall.
module fp_scoreboard
  import fp_types_pkg::*;
#(
  parameter int NUM_FPR = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [FPR_W-1:0]      set_idx,
  input  logic                  clr_en,
  input  logic [FPR_W-1:0]      clr_idx,
  input  logic [3:0][FPR_W-1:0] q_idx,
  output logic [3:0]            q_busy
);

  logic [NUM_FPR-1:0] busy;
  logic [NUM_FPR-1:0] set_mask;
  logic [NUM_FPR-1:0] clr_mask;
  logic [NUM_FPR-1:0] busy_eff;

  // One-hot set/clear masks and the writeback-adjusted busy view.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_eff = busy & ~clr_mask;
  end

  // Hazard lookups for the head op's rs1/rs2/rs3/rd.
  always_comb begin
    q_busy = '0;
    for (int i = 0; i < 4; i++) begin
      q_busy[i] = busy_eff[q_idx[i]];
    end
  end

  // Clear first, then set, so an issue to the register being retired keeps it busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/fp_issue_queue.sv
// In-order FP issue queue: small FIFO of decoded ops, head released to the
// execute unit only when free of RAW/WAW hazards on FP registers.
// Optional feature macro: FP_ISSUE_FLUSH_EN adds a flush port that empties
// the FIFO (scoreboard untouched, in-flight ops still write back).
module fp_issue_queue
  import fp_types_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_FPR = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  fp_dec_op_t             in_op,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output fp_dec_op_t             iss_op,
  input  logic                   wb_valid,
  input  logic [FPR_W-1:0]       wb_rd,
`ifdef FP_ISSUE_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fp_dec_op_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fp_dec_op_t head;
  logic not_empty;
  logic enq;
  logic deq;
  logic flush_i;
  logic hazard;
  logic chk_rs1;
  logic chk_rs2;
  logic chk_rs3;
  logic chk_rd;
  logic [3:0][FPR_W-1:0] q_idx;
  logic [3:0] q_busy;

`ifdef FP_ISSUE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Head op decode and handshake qualification.
  always_comb begin
    head      = mem[rd_ptr];
    not_empty = (count != '0);
    in_ready  = (count != CW'(DEPTH));
    // Integer-source OP-FP ops (e.g. FCVT.S.W) still check rs1; the extra stall is harmless.
    chk_rs1   = (head.fp_op == OPC_OP_FP) || is_fma(head.fp_op);
    chk_rs2   = head.fp_read;
    chk_rs3   = is_fma(head.fp_op);
    chk_rd    = head.fp_write;
    q_idx[0]  = head.rs1;
    q_idx[1]  = head.rs2;
    q_idx[2]  = head.rs3;
    q_idx[3]  = head.rd;
    hazard    = (chk_rs1 && q_busy[0]) || (chk_rs2 && q_busy[1]) ||
                (chk_rs3 && q_busy[2]) || (chk_rd && q_busy[3]);
    iss_valid = not_empty && !hazard && !flush_i;
    // Memory contents are not reset, so present zeros while the queue is empty.
    iss_op    = not_empty ? head : '0;
    enq       = in_valid && in_ready && !flush_i;
    deq       = iss_valid && iss_ready;
  end

  fp_scoreboard #(
    .NUM_FPR (NUM_FPR)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (deq && head.fp_write),
    .set_idx (head.rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .q_idx   (q_idx),
    .q_busy  (q_busy)
  );

  // Entry storage; only the pointers need reset.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_op;
  end

  // Pointer and occupancy tracking; flush wins over any same-cycle enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Bench for fp_issue_queue: ops accepted by the queue are pushed to an
// expected queue and compared against iss_op when each one issues.
module tb_fp_issue_queue;
  import fp_types_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  fp_dec_op_t in_op = '0;
  logic       iss_valid;
  logic       iss_ready = 1'b0;
  fp_dec_op_t iss_op;
  logic       wb_valid = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [$clog2(DEPTH):0] count;
`ifdef FP_ISSUE_FLUSH_EN
  logic       flush = 1'b0;
`endif

  fp_dec_op_t exp_q[$];
  fp_dec_op_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_issue_queue #(.DEPTH(DEPTH), .NUM_FPR(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_op    (iss_op),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
`ifdef FP_ISSUE_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic fp_dec_op_t mk(input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                                    input logic [4:0] r3, input logic [4:0] d,
                                    input logic rd_f, input logic wr_f);
    fp_dec_op_t o;
    o.fp_op    = opc;
    o.rs1      = r1;
    o.rs2      = r2;
    o.rs3      = r3;
    o.rd       = d;
    o.offset   = 12'($urandom);
    o.fp_read  = rd_f;
    o.fp_write = wr_f;
    o.rm       = 3'($urandom);
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input fp_dec_op_t op);
    int   waited;
    logic ok;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    while (!in_ready && waited < 20) begin
      cyc();
      waited++;
    end
    ok = in_ready;
    check_eq("enq_accept", 64'(ok), 64'd1);
    @(posedge clk);
    if (ok) exp_q.push_back(op);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    cyc();
    wb_valid = 1'b0;
  endtask

  // Issue monitor: every accepted issue must match the oldest expected op.
  always @(negedge clk) begin
    if (rst && iss_valid && iss_ready) begin
      check_eq("iss_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("iss_op", 64'(iss_op), 64'(mon_e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OPC_FLW  = 7'b0000111;
  localparam logic [6:0] OPC_FMA  = 7'b1000011;
  localparam logic [6:0] OPC_NOFP = 7'b0001111;

  initial begin
    // reset state
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_iss_valid", 64'(iss_valid), 64'd0);
    check_eq("rst_iss_op", 64'(iss_op), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_busy", 64'(dut.u_sb.busy), 64'd0);
    rst = 1'b1;
    cyc();

    // RAW on f5
    iss_ready = 1'b1;
    enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1));
    enq(mk(OPC_OP_FP, 5'd5, 5'd6, 5'd0, 5'd8, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      check_eq("raw_stall", 64'(iss_valid), 64'd0);
      cyc();
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    check_eq("raw_wb_release", 64'(iss_valid), 64'd1);
    cyc();
    wb_valid = 1'b0;
    check_eq("raw_busy", 64'(dut.u_sb.busy), 64'h100);
    wb(5'd8);
    check_eq("raw_busy_clear", 64'(dut.u_sb.busy), 64'd0);

    // WAW on f3
    enq(mk(OPC_FLW, 5'd10, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1));
    enq(mk(OPC_FLW, 5'd11, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1));
    check_eq("waw_stall0", 64'(iss_valid), 64'd0);
    cyc();
    check_eq("waw_stall1", 64'(iss_valid), 64'd0);
    check_eq("waw_busy", 64'(dut.u_sb.busy), 64'h8);
    wb(5'd20);
    check_eq("wb_nonbusy", 64'(dut.u_sb.busy), 64'h8);
    check_eq("waw_still_stalled", 64'(iss_valid), 64'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    #1;
    check_eq("waw_wb_release", 64'(iss_valid), 64'd1);
    cyc();
    wb_valid = 1'b0;
    check_eq("waw_set_wins", 64'(dut.u_sb.busy), 64'h8);
    wb(5'd3);
    check_eq("waw_busy_clear", 64'(dut.u_sb.busy), 64'd0);

    // FMA rs3 hazard, OP-FP ignores rs3, non-FP op never stalls
    enq(mk(OPC_FLW, 5'd10, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1));
    cyc();
    check_eq("fma_busy7", 64'(dut.u_sb.busy), 64'h80);
    enq(mk(OPC_FMA, 5'd1, 5'd2, 5'd7, 5'd10, 1'b1, 1'b1));
    check_eq("fma_rs3_stall0", 64'(iss_valid), 64'd0);
    cyc();
    check_eq("fma_rs3_stall1", 64'(iss_valid), 64'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    #1;
    check_eq("fma_wb_release", 64'(iss_valid), 64'd1);
    cyc();
    wb_valid = 1'b0;
    enq(mk(OPC_FLW, 5'd10, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1));
    cyc();
    check_eq("fma_busy_7_10", 64'(dut.u_sb.busy), 64'h480);
    enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd7, 5'd11, 1'b1, 1'b1));
    check_eq("opfp_ignores_rs3", 64'(iss_valid), 64'd1);
    cyc();
    enq(mk(OPC_NOFP, 5'd7, 5'd10, 5'd11, 5'd7, 1'b0, 1'b0));
    check_eq("nofp_no_stall", 64'(iss_valid), 64'd1);
    cyc();
    check_eq("fma_busy_final", 64'(dut.u_sb.busy), 64'hC80);
    wb(5'd7);
    wb(5'd10);
    wb(5'd11);
    check_eq("fma_busy_clear", 64'(dut.u_sb.busy), 64'd0);

    // Full / backpressure
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'(12 + i), 1'b1, 1'b1));
    end
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_op    = mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'd16, 1'b1, 1'b1);
    cyc();
    check_eq("full_hold_count", 64'(count), 64'd4);
    cyc();
    check_eq("full_hold_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    iss_ready = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cyc();
      check_eq("drain_count", 64'(count), 64'(i));
    end
    check_eq("drain_busy", 64'(dut.u_sb.busy), 64'hF000);
    enq(in_op);
    cyc();
    check_eq("fifth_issued", 64'(count), 64'd0);
    for (int r = 12; r <= 16; r++) wb(5'(r));
    check_eq("full_busy_clear", 64'(dut.u_sb.busy), 64'd0);

    // Reset mid-stream
    enq(mk(OPC_FLW, 5'd10, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1));
    cyc();
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'(20 + i), 1'b1, 1'b1));
    end
    check_eq("pre_rst_count", 64'(count), 64'd3);
    check_eq("pre_rst_busy", 64'(dut.u_sb.busy), 64'h20);
    #1;
    rst = 1'b0;
    #1;
    check_eq("async_rst_count", 64'(count), 64'd0);
    check_eq("async_rst_iss_valid", 64'(iss_valid), 64'd0);
    check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("async_rst_busy", 64'(dut.u_sb.busy), 64'd0);
    check_eq("async_rst_iss_op", 64'(iss_op), 64'd0);
    exp_q.delete();
    #1;
    rst = 1'b1;
    cyc();

`ifdef FP_ISSUE_FLUSH_EN
    // Flush keeps scoreboard, drops queued ops and same-cycle enqueue
    iss_ready = 1'b1;
    enq(mk(OPC_FLW, 5'd10, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1));
    cyc();
    iss_ready = 1'b0;
    enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'd24, 1'b1, 1'b1));
    enq(mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'd25, 1'b1, 1'b1));
    check_eq("pre_flush_count", 64'(count), 64'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = mk(OPC_OP_FP, 5'd1, 5'd2, 5'd0, 5'd26, 1'b1, 1'b1);
    #1;
    check_eq("flush_iss_gate", 64'(iss_valid), 64'd0);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_busy9", 64'(dut.u_sb.busy), 64'h200);
    exp_q.delete();
    iss_ready = 1'b1;
    cyc();
    check_eq("flush_drop_enq", 64'(count), 64'd0);
    check_eq("flush_no_issue", 64'(iss_valid), 64'd0);
    wb(5'd9);
`endif

    check_eq("end_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
